// File: rtl/spectrum_peak_picker.sv
// Per-frame band peak picker: tracks the loudest bin in four spectral bands
// and queues one fingerprint record per complete 1024-bin frame.
module spectrum_peak_picker #(
  parameter logic [15:0] MIN_MAG    = 16'd64,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mag_valid,
  input  logic [15:0] mag_data,
  input  logic [10:0] mag_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [39:0] out_data,
  output logic        sync_error,
  output logic        overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    WAIT_SYNC,
    ACCUM
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] exp_idx;
  logic [10:0] exp_nxt;
  logic [7:0]  frame_id;
  logic [7:0]  frame_nxt;
  logic        sync_nxt;
  logic        push;
  logic        take;
  logic        clr;
  logic [39:0] rec;
  logic [3:0]  in_band;

  logic [15:0] max_q   [4];
  logic [7:0]  bin_q   [4];
  logic [15:0] max_upd [4];
  logic [7:0]  bin_upd [4];
  logic [15:0] max_nxt [4];
  logic [7:0]  bin_nxt [4];

  always_comb begin
    in_band[0] = (mag_index >= 11'd8)   && (mag_index <= 11'd31);
    in_band[1] = (mag_index >= 11'd32)  && (mag_index <= 11'd63);
    in_band[2] = (mag_index >= 11'd64)  && (mag_index <= 11'd127);
    in_band[3] = (mag_index >= 11'd128) && (mag_index <= 11'd255);
  end

  // Sequencing: decide whether this sample joins a frame and whether
  // the frame in progress must be thrown away.
  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_idx;
    frame_nxt = frame_id;
    sync_nxt  = 1'b0;
    push      = 1'b0;
    take      = 1'b0;
    clr       = 1'b0;
    if (mag_valid) begin
      unique case (state)
        WAIT_SYNC: begin
          if (mag_index == 11'd0) begin
            take = 1'b1;
            clr  = 1'b1;
          end
        end
        ACCUM: begin
          if (mag_index == exp_idx) begin
            take = 1'b1;
          end else begin
            sync_nxt = 1'b1;
            clr      = 1'b1;
            if (mag_index == 11'd0) begin
              take = 1'b1;
            end else begin
              state_nxt = WAIT_SYNC;
              exp_nxt   = 11'd0;
            end
          end
        end
        default: state_nxt = WAIT_SYNC;
      endcase
    end
    if (take) begin
      state_nxt = ACCUM;
      if (mag_index == 11'd1023) begin
        exp_nxt   = 11'd0;
        push      = 1'b1;
        frame_nxt = frame_id + 8'd1;
      end else begin
        exp_nxt = mag_index + 11'd1;
      end
    end
  end

  // Trackers include the current sample, so the record sees bin 1023 too.
  always_comb begin
    rec = '0;
    rec[39:32] = frame_id;
    for (int b = 0; b < 4; b++) begin
      max_upd[b] = clr ? 16'd0 : max_q[b];
      bin_upd[b] = clr ? 8'd0 : bin_q[b];
      if (take && in_band[b] && (mag_data > max_upd[b])) begin
        max_upd[b] = mag_data;
        bin_upd[b] = mag_index[7:0];
      end
      rec[8*b +: 8] = (max_upd[b] >= MIN_MAG) ? bin_upd[b] : 8'd0;
      max_nxt[b] = push ? 16'd0 : max_upd[b];
      bin_nxt[b] = push ? 8'd0 : bin_upd[b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_SYNC;
      exp_idx    <= 11'd0;
      frame_id   <= 8'd0;
      sync_error <= 1'b0;
      for (int b = 0; b < 4; b++) begin
        max_q[b] <= 16'd0;
        bin_q[b] <= 8'd0;
      end
    end else begin
      state      <= state_nxt;
      exp_idx    <= exp_nxt;
      frame_id   <= frame_nxt;
      sync_error <= sync_nxt;
      for (int b = 0; b < 4; b++) begin
        max_q[b] <= max_nxt[b];
        bin_q[b] <= bin_nxt[b];
      end
    end
  end

  logic [39:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr_en;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr] : 40'd0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= rec;
    end
  end

  // A full FIFO keeps its contents; the new record is the one lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      count <= count + CW'(wr_en) - CW'(pop);
      if (push && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_peak_picker.sv
// Directed bench for spectrum_peak_picker: frame sequencing, peak bins,
// sync loss, FIFO full/drain behaviour and reset recovery.
module tb_spectrum_peak_picker;

  logic        clk = 1'b0;
  logic        reset;
  logic        mag_valid;
  logic [15:0] mag_data;
  logic [10:0] mag_index;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_data;
  logic        sync_error;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_sync   = 0;

  logic [15:0] spec [1024];
  logic [7:0]  drain_fid [4];

  spectrum_peak_picker dut (
    .clk        (clk),
    .reset      (reset),
    .mag_valid  (mag_valid),
    .mag_data   (mag_data),
    .mag_index  (mag_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sync_error (sync_error),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (out_valid === 1'b1) n_valid++;
    if (sync_error === 1'b1) n_sync++;
  endtask

  task automatic send(input int idx);
    @(negedge clk);
    observe();
    mag_valid = 1'b1;
    mag_index = 11'(idx);
    mag_data  = spec[idx];
  endtask

  task automatic idle();
    @(negedge clk);
    observe();
    mag_valid = 1'b0;
    mag_index = 11'd0;
    mag_data  = 16'd0;
  endtask

  task automatic stream(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(i);
  endtask

  task automatic clear_spec();
    for (int i = 0; i < 1024; i++) spec[i] = 16'd0;
  endtask

  task automatic spec_a();
    clear_spec();
    spec[20]  = 16'd500;
    spec[40]  = 16'd300;
    spec[100] = 16'd70;
    spec[200] = 16'd10;
  endtask

  task automatic do_reset(input int idx);
    @(negedge clk);
    reset     = 1'b1;
    mag_valid = 1'b1;
    mag_index = 11'(idx);
    mag_data  = 16'hffff;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_sync", 64'(sync_error), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset     = 1'b0;
    mag_valid = 1'b0;
    mag_index = 11'd0;
    mag_data  = 16'd0;
  endtask

  initial begin
    reset     = 1'b0;
    mag_valid = 1'b0;
    mag_data  = 16'd0;
    mag_index = 11'd0;
    out_ready = 1'b1;
    clear_spec();
    do_reset(0);

    // Start mid-frame: nothing may come out
    n_valid = 0;
    n_sync  = 0;
    stream(500, 1023);
    idle();
    chk("late_start_valid", 64'(n_valid), 64'd0);
    chk("late_start_sync", 64'(n_sync), 64'd0);

    // Basic frame, one-cycle latency
    spec_a();
    stream(0, 1023);
    chk("lat_before", 64'(out_valid), 64'd0);
    idle();
    chk("a_valid", 64'(out_valid), 64'd1);
    chk("a_data", 64'(out_data), 64'h00_00_00_64_28_14);
    idle();
    chk("a_popped", 64'(out_valid), 64'd0);

    // Ties, MIN_MAG edge, back-to-back frames
    clear_spec();
    spec[10]  = 16'd900;
    spec[12]  = 16'd900;
    spec[40]  = 16'd50;
    spec[70]  = 16'd64;
    spec[128] = 16'hffff;
    spec[255] = 16'hffff;
    n_sync = 0;
    stream(0, 1023);
    send(0);
    chk("b1_valid", 64'(out_valid), 64'd1);
    chk("b1_data", 64'(out_data), 64'h00_01_80_46_00_0a);
    stream(1, 1023);
    idle();
    chk("b2_data", 64'(out_data), 64'h00_02_80_46_00_0a);
    chk("b2_sync", 64'(n_sync), 64'd0);
    idle();

    // Index skip, stray samples, then restart on index 0
    spec_a();
    n_valid = 0;
    n_sync  = 0;
    stream(0, 300);
    send(302);
    idle();
    chk("skip_pulse", 64'(sync_error), 64'd1);
    idle();
    chk("skip_pulse_end", 64'(sync_error), 64'd0);
    stream(303, 400);
    spec[30] = 16'd9999;
    stream(0, 50);
    spec[30] = 16'd0;
    send(0);
    stream(1, 1023);
    idle();
    chk("resync_data", 64'(out_data), 64'h00_03_00_64_28_14);
    chk("resync_nvalid", 64'(n_valid), 64'd1);
    chk("resync_nsync", 64'(n_sync), 64'd2);
    idle();

    // Fill the FIFO, drop one, then push+pop while full
    out_ready = 1'b0;
    for (int f = 0; f < 4; f++) stream(0, 1023);
    idle();
    chk("full4_ovf", 64'(overflow), 64'd0);
    chk("full4_head", 64'(out_data[39:32]), 64'd4);
    stream(0, 1023);
    idle();
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("hold_head", 64'(out_data), 64'h04_00_64_28_14);
    stream(0, 1022);
    send(1023);
    out_ready = 1'b1;
    idle();
    drain_fid[0] = 8'd5;
    drain_fid[1] = 8'd6;
    drain_fid[2] = 8'd7;
    drain_fid[3] = 8'd9;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_fid", 64'(out_data[39:32]), 64'(drain_fid[k]));
      idle();
    end
    chk("drained", 64'(out_valid), 64'd0);
    stream(0, 1023);
    idle();
    chk("after_drain", 64'(out_data), 64'h0a_00_64_28_14);
    idle();

    // Reset mid-frame, then one clean frame
    stream(0, 700);
    do_reset(701);
    n_valid = 0;
    n_sync  = 0;
    stream(0, 1023);
    idle();
    chk("post_rst_data", 64'(out_data), 64'h00_00_64_28_14);
    chk("post_rst_ovf", 64'(overflow), 64'd0);
    idle();
    chk("post_rst_nvalid", 64'(n_valid), 64'd1);
    chk("post_rst_nsync", 64'(n_sync), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
